// File: rtl/alu_16bit_guard_pkg.sv
// Shared types and constants for the 16-bit ALU guard.
// Also used by the golden reference model.
package alu_16bit_guard_pkg;

    localparam int W = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAN   = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_ALARM   = 2'b10
    } state_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
        logic         n;
    } alu_out_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        alu_out_t     out;
    } s1_t;

endpackage

// File: rtl/alu_16bit_golden.sv
// Combinational reference ALU: result and carry/zero/overflow/negative.
module alu_16bit_golden
    import alu_16bit_guard_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         overflow,
    output logic         negative
);

    logic [W:0] sum;
    logic [W:0] diff;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} + {1'b0, ~b} + 17'd1;
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        unique case (op)
            OP_ADD: begin
                result   = sum[W-1:0];
                carry    = sum[W];
                overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                result   = diff[W-1:0];
                carry    = diff[W];
                overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
        endcase
        zero     = (result == '0);
        negative = result[W-1];
    end

endmodule

// File: rtl/alu_16bit_guard.sv
// Two-stage runtime checker that compares an ALU against a golden model
// and latches a Trojan-suspected alarm after enough mismatches.
module alu_16bit_guard
    import alu_16bit_guard_pkg::*;
#(
    parameter int ALARM_THRESHOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   op,
    input  logic [W-1:0] result,
    input  logic         carry,
    input  logic         zero,
    input  logic         overflow,
    input  logic         negative,
    input  logic         alarm_ack,
    output logic         mismatch,
    output logic         alarm,
    output logic [1:0]   state,
    output logic [15:0]  check_count,
    output logic [7:0]   mismatch_count,
    output logic [W-1:0] fail_a,
    output logic [W-1:0] fail_b,
    output logic [1:0]   fail_op
);

    localparam logic [7:0] TH = 8'(ALARM_THRESHOLD);

    s1_t          s1_q, s1_d;
    logic         valid_s1_q, valid_s1_d;
    logic         mismatch_q, mismatch_d;
    logic         alarm_q, alarm_d;
    state_t       state_q, state_d;
    logic [15:0]  check_cnt_q, check_cnt_d;
    logic [7:0]   mm_cnt_q, mm_cnt_d;
    logic [W-1:0] fail_a_q, fail_a_d;
    logic [W-1:0] fail_b_q, fail_b_d;
    logic [1:0]   fail_op_q, fail_op_d;
    logic         armed_q, armed_d;

    logic [W-1:0] g_res;
    logic         g_c, g_z, g_v, g_n;
    logic         mm, ack_hit, armed_eff;
    logic [7:0]   cnt_base;

    alu_16bit_golden u_golden (
        .a        (s1_q.a),
        .b        (s1_q.b),
        .op       (s1_q.op),
        .result   (g_res),
        .carry    (g_c),
        .zero     (g_z),
        .overflow (g_v),
        .negative (g_n)
    );

    always_comb begin
        s1_d       = s1_q;
        valid_s1_d = in_valid;
        if (in_valid) begin
            s1_d = '{a: A, b: B, op: op,
                     out: '{res: result, c: carry, z: zero,
                            v: overflow, n: negative}};
        end

        mm = valid_s1_q &&
             ({g_res, g_c, g_z, g_v, g_n} != s1_q.out);
        mismatch_d = mm;

        check_cnt_d = check_cnt_q;
        if (valid_s1_q && (check_cnt_q != 16'hFFFF)) begin
            check_cnt_d = check_cnt_q + 16'd1;
        end

        // An ack in ALARM restarts counting; a same-cycle mismatch counts on top.
        ack_hit  = (state_q == ST_ALARM) && alarm_ack;
        cnt_base = ack_hit ? 8'd0 : mm_cnt_q;
        mm_cnt_d = cnt_base;
        if (mm && (cnt_base != 8'hFF)) begin
            mm_cnt_d = cnt_base + 8'd1;
        end

        armed_eff = armed_q || ack_hit;
        armed_d   = armed_eff;
        fail_a_d  = fail_a_q;
        fail_b_d  = fail_b_q;
        fail_op_d = fail_op_q;
        if (mm && armed_eff) begin
            fail_a_d  = s1_q.a;
            fail_b_d  = s1_q.b;
            fail_op_d = s1_q.op;
            armed_d   = 1'b0;
        end

        state_d = state_q;
        unique case (state_q)
            ST_CLEAN, ST_SUSPECT: begin
                if (mm) begin
                    state_d = (mm_cnt_d >= TH) ? ST_ALARM : ST_SUSPECT;
                end
            end
            ST_ALARM: begin
                if (alarm_ack && !mm) begin
                    state_d = ST_CLEAN;
                end
            end
            default: state_d = ST_CLEAN;
        endcase
        alarm_d = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            valid_s1_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            alarm_q     <= 1'b0;
            state_q     <= ST_CLEAN;
            check_cnt_q <= '0;
            mm_cnt_q    <= '0;
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_op_q   <= '0;
            armed_q     <= 1'b1;
        end else begin
            s1_q        <= s1_d;
            valid_s1_q  <= valid_s1_d;
            mismatch_q  <= mismatch_d;
            alarm_q     <= alarm_d;
            state_q     <= state_d;
            check_cnt_q <= check_cnt_d;
            mm_cnt_q    <= mm_cnt_d;
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_op_q   <= fail_op_d;
            armed_q     <= armed_d;
        end
    end

    assign mismatch       = mismatch_q;
    assign alarm          = alarm_q;
    assign state          = state_q;
    assign check_count    = check_cnt_q;
    assign mismatch_count = mm_cnt_q;
    assign fail_a         = fail_a_q;
    assign fail_b         = fail_b_q;
    assign fail_op        = fail_op_q;

endmodule

// File: tb/tb_alu_16bit_guard.sv
// Directed bench for alu_16bit_guard with thresholds 1 and 3.
module tb_alu_16bit_guard;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        alarm_ack;
    logic [15:0] A, B, result;
    logic [1:0]  op;
    logic        carry, zero, overflow, negative;

    logic        mm1, al1, mm3, al3;
    logic [1:0]  st1, st3, fo1, fo3;
    logic [15:0] cc1, cc3, fa1, fa3, fb1, fb3;
    logic [7:0]  mc1, mc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_16bit_guard #(.ALARM_THRESHOLD(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .op(op), .result(result), .carry(carry), .zero(zero),
        .overflow(overflow), .negative(negative),
        .alarm_ack(alarm_ack), .mismatch(mm1), .alarm(al1),
        .state(st1), .check_count(cc1), .mismatch_count(mc1),
        .fail_a(fa1), .fail_b(fb1), .fail_op(fo1)
    );

    alu_16bit_guard #(.ALARM_THRESHOLD(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .op(op), .result(result), .carry(carry), .zero(zero),
        .overflow(overflow), .negative(negative),
        .alarm_ack(alarm_ack), .mismatch(mm3), .alarm(al3),
        .state(st3), .check_count(cc3), .mismatch_count(mc3),
        .fail_a(fa3), .fail_b(fb3), .fail_op(fo3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] o, input logic [15:0] r,
                         input logic [3:0] f);
        A = a; B = b; op = o; result = r;
        {carry, zero, overflow, negative} = f;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] o, input logic [15:0] r,
                        input logic [3:0] f);
        drive(a, b, o, r, f);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        alarm_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Independent integer model of a correct ALU: {c,z,v,n} flags.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] o,
                                  output logic [15:0] r,
                                  output logic [3:0] f);
        int ua, ub, sa, sb, t, s;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        t = 0; c = 1'b0; v = 1'b0;
        case (o)
            2'd0: begin
                t = ua + ub; c = (t > 65535);
                s = sa + sb; v = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                t = ua - ub; c = (ua >= ub);
                s = sa - sb; v = (s > 32767) || (s < -32768);
            end
            2'd2: t = ua & ub;
            default: t = ua | ub;
        endcase
        r = t[15:0];
        f = {c, (r == 16'h0), v, r[15]};
    endfunction

    task automatic test_reset();
        in_valid = 1'b0; alarm_ack = 1'b0;
        A = '0; B = '0; op = '0; result = '0;
        {carry, zero, overflow, negative} = 4'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({mm1, al1, st1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000", {mm1, al1, st1});
        end
        checks++;
        if ({cc1, mc1} !== 24'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 000000", {cc1, mc1});
        end
        checks++;
        if ({fa1, fb1, fo1} !== 34'h0) begin
            errors++;
            $display("FAIL reset_fail got %h want 0", {fa1, fb1, fo1});
        end
        rst = 1'b0;
    endtask

    task automatic test_add_pass();
        do_reset();
        send(16'hFFFF, 16'hFFFF, 2'b00, 16'hFFFE, 4'b1001);
        step();
        checks++;
        if (mm1 !== 1'b0) begin
            errors++; $display("FAIL add_pass_mm got %b want 0", mm1);
        end
        checks++;
        if (cc1 !== 16'd1) begin
            errors++; $display("FAIL add_pass_cc got %0d want 1", cc1);
        end
        checks++;
        if (st1 !== 2'b00) begin
            errors++; $display("FAIL add_pass_st got %b want 00", st1);
        end
    endtask

    task automatic test_trojan();
        do_reset();
        send(16'hFFFF, 16'hFFFF, 2'b00, 16'h0000, 4'b1100);
        checks++;
        if (mm1 !== 1'b0) begin
            errors++; $display("FAIL trojan_mm_early got %b want 0", mm1);
        end
        step();
        checks++;
        if ({mm1, al1, st1} !== 4'b1110) begin
            errors++;
            $display("FAIL trojan_pulse got %b want 1110", {mm1, al1, st1});
        end
        checks++;
        if ({fa1, fb1, fo1} !== {16'hFFFF, 16'hFFFF, 2'b00}) begin
            errors++;
            $display("FAIL trojan_fail got %h %h %b want ffff ffff 00",
                     fa1, fb1, fo1);
        end
        checks++;
        if (mc1 !== 8'd1) begin
            errors++; $display("FAIL trojan_mc got %0d want 1", mc1);
        end
        step();
        checks++;
        if ({mm1, al1} !== 2'b01) begin
            errors++; $display("FAIL trojan_after got %b want 01", {mm1, al1});
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        drive(16'h8000, 16'h8000, 2'b00, 16'h0000, 4'b1110); step();
        drive(16'hFFFF, 16'h0001, 2'b01, 16'hFFFE, 4'b1001); step();
        drive(16'h0000, 16'h0001, 2'b01, 16'hFFFF, 4'b0001); step();
        drive(16'h8000, 16'h0001, 2'b01, 16'h7FFF, 4'b1010); step();
        drive(16'hF0F0, 16'h0FF0, 2'b10, 16'h00F0, 4'b0000); step();
        drive(16'h8000, 16'h0001, 2'b11, 16'h8001, 4'b0001); step();
        drive(16'h5555, 16'hAAAA, 2'b10, 16'h0000, 4'b0100); step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({mc1, st1} !== 10'h0) begin
            errors++;
            $display("FAIL bound_clean got mc=%0d st=%b want 0 00", mc1, st1);
        end
        checks++;
        if (cc1 !== 16'd7) begin
            errors++; $display("FAIL bound_cc got %0d want 7", cc1);
        end
        send(16'h0001, 16'h0001, 2'b00, 16'h0002, 4'b1000);
        step();
        checks++;
        if ({mm1, mc1} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL flag_only got mm=%b mc=%0d want 1 1", mm1, mc1);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        drive(16'h1111, 16'h0001, 2'b00, 16'h0000, 4'b0000); step();
        drive(16'h2222, 16'h0001, 2'b00, 16'h0000, 4'b0000); step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({st3, al3, mc3} !== {2'b01, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL th_suspect got st=%b al=%b mc=%0d want 01 0 2",
                     st3, al3, mc3);
        end
        checks++;
        if (fa3 !== 16'h1111) begin
            errors++; $display("FAIL th_first got %h want 1111", fa3);
        end
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        checks++;
        if ({st3, mc3} !== {2'b01, 8'd2}) begin
            errors++;
            $display("FAIL th_ack_ign got st=%b mc=%0d want 01 2", st3, mc3);
        end
        send(16'h3333, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        step();
        checks++;
        if ({st3, al3, mc3} !== {2'b10, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL th_alarm got st=%b al=%b mc=%0d want 10 1 3",
                     st3, al3, mc3);
        end
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        checks++;
        if ({st3, al3, mc3} !== 11'h0) begin
            errors++;
            $display("FAIL th_ack got st=%b al=%b mc=%0d want 00 0 0",
                     st3, al3, mc3);
        end
        send(16'h4444, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        step();
        checks++;
        if ({fa3, st3} !== {16'h4444, 2'b01}) begin
            errors++;
            $display("FAIL th_rearm got fa=%h st=%b want 4444 01", fa3, st3);
        end
    endtask

    task automatic test_ack_collide();
        do_reset();
        send(16'hAAAA, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        step();
        checks++;
        if (st1 !== 2'b10) begin
            errors++; $display("FAIL coll_pre got %b want 10", st1);
        end
        drive(16'h5555, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        step();
        in_valid = 1'b0;
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        checks++;
        if ({mm1, st1, mc1, fa1} !== {1'b1, 2'b10, 8'd1, 16'h5555}) begin
            errors++;
            $display("FAIL coll got mm=%b st=%b mc=%0d fa=%h want 1 10 1 5555",
                     mm1, st1, mc1, fa1);
        end
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        checks++;
        if ({st1, mc1, cc1} !== {2'b00, 8'd0, 16'd2}) begin
            errors++;
            $display("FAIL coll_ack got st=%b mc=%0d cc=%0d want 00 0 2",
                     st1, mc1, cc1);
        end
    endtask

    task automatic test_reset_inflight();
        int pulses;
        do_reset();
        drive(16'h1111, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        step();
        drive(16'h2222, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({mm1, al1, st1, mc1, cc1} !== 28'h0) begin
            errors++;
            $display("FAIL rst_async got %h want 0", {mm1, al1, st1, mc1, cc1});
        end
        in_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (mm1 || mm3) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL rst_flight got %0d pulses want 0", pulses);
        end
        checks++;
        if ({al1, st1, mc1, cc1, fa1, fb1, fo1} !== 61'h0) begin
            errors++;
            $display("FAIL rst_outs got %h want 0",
                     {al1, st1, mc1, cc1, fa1, fb1, fo1});
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [15:0] a, b, r;
        logic [1:0]  o;
        logic [3:0]  f;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 2048; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            o = 2'(i % 4);
            model(a, b, o, r, f);
            drive(a, b, o, r, f);
            step();
            if (mm1) pulses++;
        end
        in_valid = 1'b0;
        step();
        if (mm1) pulses++;
        step();
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL b2b_pulses got %0d want 0", pulses);
        end
        checks++;
        if ({mc1, st1} !== 10'h0) begin
            errors++;
            $display("FAIL b2b_mc got mc=%0d st=%b want 0 00", mc1, st1);
        end
        checks++;
        if (cc1 !== 16'd2048) begin
            errors++; $display("FAIL b2b_cc got %0d want 2048", cc1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add_pass();
        test_trojan();
        test_boundaries();
        test_threshold();
        test_ack_collide();
        test_reset_inflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_16bit_guard.md
ALU_16BIT_GUARD -- requirements
Module: alu_16bit_guard

Interface
REQ-001 SHALL have parameter ALARM_THRESHOLD, default 1, meaning the mismatch count (1..255) at which the alarm raises.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the sample on the ports below is a valid ALU transaction.
REQ-005 SHALL have ports A and B, input, 16 each, meaning the operands presented to the ALU under test.
REQ-006 SHALL have port op, input, 2, meaning the ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-007 SHALL have port result, input, 16, meaning the ALU-under-test result, valid in the same cycle as A/B/op.
REQ-008 SHALL have ports carry, zero, overflow and negative, input, 1 each, meaning the ALU-under-test flags.
REQ-009 SHALL have port alarm_ack, input, 1, meaning a software or bench request to clear the alarm.
REQ-010 SHALL have port mismatch, output, 1, a one-cycle pulse marking a failed check.
REQ-011 SHALL have port alarm, output, 1, meaning the latched Trojan-suspected indication.
REQ-012 SHALL have port state, output, 2, meaning the FSM encoding: 00 CLEAN, 01 SUSPECT, 10 ALARM.
REQ-013 SHALL have ports check_count (16), mismatch_count (8), fail_a (16), fail_b (16) and fail_op (2), all outputs.

Function
REQ-014 SHALL form stage 1 by registering {A, B, op, result, flags} when in_valid=1 and SHALL set valid_s1 from in_valid.
REQ-015 SHALL form stage 2 by computing the golden result and flags from the stage-1 operands and comparing all five fields; mismatch SHALL pulse exactly 2 cycles after the in_valid sample.
REQ-016 SHALL compute golden ADD as the 17-bit sum A+B, with carry=bit16 and overflow=(A[15]==B[15])&&(sum[15]!=A[15]).
REQ-017 SHALL compute golden SUB as A+~B+1, with carry=bit16 (no-borrow) and overflow=(A[15]!=B[15])&&(diff[15]!=A[15]).
REQ-018 SHALL compute golden AND and OR with carry=0 and overflow=0.
REQ-019 SHALL compute zero=(result==0) and negative=result[15] for all ops.
REQ-020 SHALL increment check_count per stage-2 valid check, saturating at FFFF.
REQ-021 SHALL increment mismatch_count per mismatch, saturating at FF.
REQ-022 SHALL capture fail_a, fail_b and fail_op on the first mismatch only since reset or the last acknowledged alarm.
REQ-023 FSM: CLEAN->SUSPECT on a mismatch with the new count < ALARM_THRESHOLD; CLEAN or SUSPECT->ALARM when the new mismatch_count >= ALARM_THRESHOLD; ALARM holds until alarm_ack.
REQ-024 On alarm_ack in ALARM: the FSM SHALL go to CLEAN and SHALL clear mismatch_count and the fail_* capture arm; check_count SHALL be kept.
REQ-025 A mismatch in the same cycle as alarm_ack SHALL win: the FSM stays in ALARM, the count becomes 1 and fail_* recaptures.
REQ-026 alarm_ack outside ALARM SHALL be ignored.
REQ-027 alarm SHALL equal (state==ALARM) and SHALL be registered, asserting in the same cycle as the triggering mismatch pulse.
REQ-028 Back-to-back in_valid every cycle SHALL be checked with no lost samples (throughput 1/cycle).

Reset
REQ-029 rst SHALL clear within the same delta: pipeline valids, mismatch=0, alarm=0, state=CLEAN, all counters=0, fail_*=0.
REQ-030 Reset asserted mid-pipeline SHALL discard in-flight checks; no mismatch SHALL pulse for samples taken before deassertion.

Structure
REQ-031 A shared package SHALL hold the op encodings (OP_ADD/SUB/AND/OR), the FSM state encodings and the 16-bit width constant.
REQ-032 The golden model SHALL be a combinational sub-module alu_16bit_golden (A, B, op -> result and 4 flags), reusable by benches.

Verification
REQ-033 ADD A=FFFF B=FFFF with DUT result FFFE, carry=1, zero=0, ov=0, neg=1 -> no mismatch, check_count=1, state CLEAN.
REQ-034 ADD A=FFFF B=FFFF with DUT result 0000 (Trojan payload) -> mismatch pulse at +2 cycles, alarm=1 (threshold 1), fail_a=FFFF, fail_b=FFFF, fail_op=00.
REQ-035 ADD A=8000 B=8000 expected 0000, carry=1, zero=1, ov=1, neg=0; SUB A=FFFF B=0001 expected FFFE, carry=1, ov=0 -> both pass.
REQ-036 ALARM_THRESHOLD=3 with 2 bad vectors -> SUSPECT; a 3rd bad vector -> ALARM; alarm_ack -> CLEAN, mismatch_count=0.
REQ-037 alarm_ack coincident with a mismatch in ALARM -> state stays ALARM, mismatch_count=1; rst asserted with 2 bad samples in flight -> no mismatch pulse, all outputs 0.
REQ-038 2048 random vectors (512 per op) against a correct DUT -> mismatch_count=0, check_count=2048.
